// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin front end of the 20:1 multiplexor.
package mux_arb_pkg;

  localparam int N_REQ        = 20;
  localparam int ADDR_W       = 5;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // The counter only has to reach MAX_HOLD-1; a disabled limit still needs one bit.
  function automatic int hold_w(input int max_hold);
    return (max_hold <= 2) ? 1 : $clog2(max_hold);
  endfunction

  localparam int HOLD_W = hold_w(MAX_HOLD_DEF);

endpackage

// File: rtl/multiplexor.sv
// Shared 20:1 data multiplexor steered by the arbiter's addr.
module multiplexor
  import mux_arb_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int AW = ADDR_W
) (
  input  logic [N-1:0]  in,
  input  logic [AW-1:0] addr,
  output logic          out
);

  assign out = (int'(addr) < N) ? in[addr] : 1'b0;

endmodule

// File: rtl/rr_pick.sv
// Rotating priority pick: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int AW = ADDR_W
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] winner,
  output logic          any
);

  int idx;

  // Wrap at N rather than 2^AW so phantom requesters can never be selected.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        winner = AW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the multiplexor select and hands it to one requester at a time.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int AW       = ADDR_W,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [AW-1:0] addr,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic          timeout
);

  localparam int HW = hold_w(MAX_HOLD);

  arb_state_t    state, state_n;
  logic [AW-1:0] ptr, ptr_n, addr_n, winner;
  logic [N-1:0]  grant_n;
  logic          grant_valid_n, timeout_n, any;
  logic          user_rel, hold_rel;
  logic [HW-1:0] cnt, cnt_n;

  rr_pick #(.N(N), .AW(AW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign user_rel = done | ~req[addr];
  assign hold_rel = (MAX_HOLD != 0) && (int'(cnt) == MAX_HOLD - 1);

  always_comb begin
    state_n       = state;
    addr_n        = addr;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;
    ptr_n         = ptr;
    cnt_n         = cnt;
    case (state)
      IDLE: begin
        if (any) begin
          state_n       = GRANT;
          addr_n        = winner;
          grant_n       = {{(N-1){1'b0}}, 1'b1} << winner;
          grant_valid_n = 1'b1;
          cnt_n         = '0;
        end
      end
      GRANT: begin
        if (user_rel || hold_rel) begin
          state_n       = IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
          cnt_n         = '0;
          ptr_n         = (int'(addr) == N - 1) ? '0 : addr + 1'b1;
          // A voluntary release wins over the limit, so no timeout is reported then.
          timeout_n     = hold_rel && !user_rel;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
    end
  end

endmodule
